mem_bus_arbiter: RTL and testbench

- Shares one SRAM-like memory bus between the instruction-fetch port (PC stage) and the data port (MEM stage).
- Sequences at most one outstanding transaction at a time.
- Generates stallreq_from_pc and stallreq_from_mem for the pipeline controller.
- Honours pipeline flush by discarding in-flight instruction fetches.

---
 rtl/mem_bus_arbiter_pkg.sv | 27 ++
 rtl/mem_bus_arbiter_if.sv | 33 +++
 rtl/mem_bus_arbiter_arb_grant.sv | 47 ++++
 rtl/mem_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Shared definitions for the instruction/data memory bus arbiter:
//   - FSM state encoding
//   - bus transfer size codes
//   - default bus address/data widths
// No ports (package).
// ---------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;

    // Transfer size codes carried on bus_size / data_size.
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_I_ADDR = 3'd1,
        ST_I_DATA = 3'd2,
        ST_D_ADDR = 3'd3,
        ST_D_DATA = 3'd4
    } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_if
// SRAM-like memory bus with an address handshake (bus_req / bus_addr_ok)
// followed by a data handshake (bus_data_ok).
//   master : drives bus_req, bus_wr, bus_size, bus_addr, bus_wdata;
//            receives bus_addr_ok, bus_data_ok, bus_rdata
//   slave  : the opposite directions (memory side)
// ---------------------------------------------------------------------------
interface mem_bus_arbiter_if
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
);
    logic              bus_req;
    logic              bus_wr;
    logic [1:0]        bus_size;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter_arb_grant.sv
// ---------------------------------------------------------------------------
// arb_grant
// Combinational grant selection used while the arbiter is idle.
//   inst_req, data_req : pending requests
//   flush              : a flushed fetch is never started
//   prio_inst          : (ARB_RR_EN only) fetch holds priority this round
//   grant_inst/_data   : one-hot (or zero) grant
// Build option: ARB_RR_EN selects round-robin; otherwise data always wins.
// ---------------------------------------------------------------------------
module arb_grant (
    input  logic inst_req,
    input  logic data_req,
    input  logic flush,
`ifdef ARB_RR_EN
    input  logic prio_inst,
`endif
    output logic grant_inst,
    output logic grant_data
);
    logic inst_ok_s;

    // Pick the winner among eligible requesters.
    always_comb begin
        inst_ok_s  = inst_req & ~flush;
        grant_inst = 1'b0;
        grant_data = 1'b0;
`ifdef ARB_RR_EN
        if (inst_ok_s && (prio_inst || !data_req)) begin
            grant_inst = 1'b1;
        end else if (data_req) begin
            grant_data = 1'b1;
        end else begin
            grant_inst = 1'b0;
            grant_data = 1'b0;
        end
`else
        if (data_req) begin
            grant_data = 1'b1;
        end else if (inst_ok_s) begin
            grant_inst = 1'b1;
        end else begin
            grant_inst = 1'b0;
            grant_data = 1'b0;
        end
`endif
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one SRAM-like bus between the fetch port and the data port, with at
// most one outstanding transaction.
//   clk, rst (async, active low), flush
//   inst_* : fetch request / completion, stallreq_from_pc
//   data_* : load/store request / completion, stallreq_from_mem
//   bus    : mem_bus_arbiter_if.master towards memory
// Build option: ARB_RR_EN enables round-robin arbitration between the ports.
// ---------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_valid,
    output logic              stallreq_from_pc,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_valid,
    output logic              stallreq_from_mem,
    mem_bus_arbiter_if.master bus
);
    arb_state_e state_r;
    logic       discard_r;
    logic       grant_inst_s;
    logic       grant_data_s;
    logic       inst_done_s;
    logic       data_done_s;
`ifdef ARB_RR_EN
    logic       prio_inst_r;
`endif

    arb_grant u_arb_grant (
        .inst_req   (inst_req),
        .data_req   (data_req),
        .flush      (flush),
`ifdef ARB_RR_EN
        .prio_inst  (prio_inst_r),
`endif
        .grant_inst (grant_inst_s),
        .grant_data (grant_data_s)
    );

    // Completion strobes and stall requests; valid must be same-cycle as data_ok.
    always_comb begin
        inst_done_s       = (state_r == ST_I_DATA) & bus.bus_data_ok;
        data_done_s       = (state_r == ST_D_DATA) & bus.bus_data_ok;
        // A fetch flushed earlier (discard) or right now (flush) must not retire.
        inst_valid        = inst_done_s & ~discard_r & ~flush;
        data_valid        = data_done_s;
        stallreq_from_pc  = inst_req & ~inst_valid;
        stallreq_from_mem = data_req & ~data_valid;
        inst_rdata        = bus.bus_rdata;
        data_rdata        = bus.bus_rdata;
    end

    // Transaction sequencer with registered bus outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            discard_r     <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.bus_wr    <= 1'b0;
            bus.bus_size  <= 2'd0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
`ifdef ARB_RR_EN
            prio_inst_r   <= 1'b1;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_data_s) begin
                        state_r       <= ST_D_ADDR;
                        bus.bus_req   <= 1'b1;
                        bus.bus_wr    <= data_wr;
                        bus.bus_size  <= data_size;
                        bus.bus_addr  <= data_addr;
                        bus.bus_wdata <= data_wdata;
                    end else if (grant_inst_s) begin
                        state_r       <= ST_I_ADDR;
                        bus.bus_req   <= 1'b1;
                        bus.bus_wr    <= 1'b0;
                        bus.bus_size  <= SIZE_W;
                        bus.bus_addr  <= inst_addr;
                        bus.bus_wdata <= '0;
                    end else begin
                        bus.bus_req   <= 1'b0;
                    end
                end
                ST_I_ADDR: begin
                    // The bus cannot withdraw a request: keep it, drop the result later.
                    if (flush) begin
                        discard_r <= 1'b1;
                    end
                    if (bus.bus_addr_ok) begin
                        state_r     <= ST_I_DATA;
                        bus.bus_req <= 1'b0;
                    end
                end
                ST_I_DATA: begin
                    if (bus.bus_data_ok) begin
                        // Covers both a discarded return and a flush coinciding with data_ok.
                        state_r   <= ST_IDLE;
                        discard_r <= 1'b0;
`ifdef ARB_RR_EN
                        prio_inst_r <= 1'b0;
`endif
                    end else if (flush) begin
                        discard_r <= 1'b1;
                    end
                end
                ST_D_ADDR: begin
                    if (bus.bus_addr_ok) begin
                        state_r     <= ST_D_DATA;
                        bus.bus_req <= 1'b0;
                    end
                end
                ST_D_DATA: begin
                    if (bus.bus_data_ok) begin
                        state_r <= ST_IDLE;
`ifdef ARB_RR_EN
                        prio_inst_r <= 1'b1;
`endif
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    discard_r   <= 1'b0;
                    bus.bus_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Self-checking bench for mem_bus_arbiter: a table of single transactions
// plus hand-written flush, arbitration and reset sequences. Expected read
// data is queued when a request is driven and popped when a valid appears.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_valid;
    logic        stallreq_from_pc;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_valid;
    logic        stallreq_from_mem;

    mem_bus_arbiter_if bus_if ();

    mem_bus_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .inst_req          (inst_req),
        .inst_addr         (inst_addr),
        .inst_rdata        (inst_rdata),
        .inst_valid        (inst_valid),
        .stallreq_from_pc  (stallreq_from_pc),
        .data_req          (data_req),
        .data_wr           (data_wr),
        .data_size         (data_size),
        .data_addr         (data_addr),
        .data_wdata        (data_wdata),
        .data_rdata        (data_rdata),
        .data_valid        (data_valid),
        .stallreq_from_mem (stallreq_from_mem),
        .bus               (bus_if.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_data;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          addr_wait;
        int          data_wait;
        logic        exp_wr;
        logic [1:0]  exp_size;
    } vec_t;

    vec_t        vecs [6];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_inst_q [$];
    logic [31:0] exp_data_q [$];
    int          inst_valid_cnt = 0;
    int          data_valid_cnt = 0;
    int          pc_stall_cnt = 0;

    function automatic vec_t mk(input logic is_data, input logic wr, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int aw, input int dw);
        vec_t v;
        v.is_data   = is_data;
        v.wr        = wr;
        v.size      = size;
        v.addr      = addr;
        v.wdata     = wdata;
        v.rdata     = rdata;
        v.addr_wait = aw;
        v.data_wait = dw;
        v.exp_wr    = is_data ? wr : 1'b0;
        v.exp_size  = is_data ? size : SIZE_W;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: scoreboard the valids at the falling edge, return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (inst_valid) begin
            inst_valid_cnt++;
            if (exp_inst_q.size() == 0) check("inst_valid_spurious", {63'd0, inst_valid}, 64'd0);
            else check("inst_rdata", {32'd0, inst_rdata}, {32'd0, exp_inst_q.pop_front()});
        end
        if (data_valid) begin
            data_valid_cnt++;
            if (exp_data_q.size() == 0) check("data_valid_spurious", {63'd0, data_valid}, 64'd0);
            else check("data_rdata", {32'd0, data_rdata}, {32'd0, exp_data_q.pop_front()});
        end
        if (stallreq_from_pc) pc_stall_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            n++;
            if (bus_if.bus_req) return;
        end
        check("bus_req_timeout", {63'd0, bus_if.bus_req}, 64'd1);
    endtask

    // Drive the bus handshake for a transaction whose address phase is now on the bus.
    task automatic serve(input vec_t v);
        check("bus_req", {63'd0, bus_if.bus_req}, 64'd1);
        check("bus_addr", {32'd0, bus_if.bus_addr}, {32'd0, v.addr});
        check("bus_wr", {63'd0, bus_if.bus_wr}, {63'd0, v.exp_wr});
        check("bus_size", {62'd0, bus_if.bus_size}, {62'd0, v.exp_size});
        if (v.wr) check("bus_wdata", {32'd0, bus_if.bus_wdata}, {32'd0, v.wdata});
        for (int i = 0; i < v.addr_wait; i++) begin
            tick();
            check("addr_wait_req", {63'd0, bus_if.bus_req}, 64'd1);
            check("addr_wait_addr", {32'd0, bus_if.bus_addr}, {32'd0, v.addr});
            check("addr_wait_stall", {63'd0, v.is_data ? stallreq_from_mem : stallreq_from_pc}, 64'd1);
        end
        bus_if.bus_addr_ok = 1'b1;
        tick();
        bus_if.bus_addr_ok = 1'b0;
        check("req_drop_after_addr_ok", {63'd0, bus_if.bus_req}, 64'd0);
        for (int i = 0; i < v.data_wait; i++) begin
            tick();
            check("data_wait_stall", {63'd0, v.is_data ? stallreq_from_mem : stallreq_from_pc}, 64'd1);
        end
        bus_if.bus_data_ok = 1'b1;
        bus_if.bus_rdata   = v.rdata;
        tick();
        bus_if.bus_data_ok = 1'b0;
        bus_if.bus_rdata   = 32'd0;
    endtask

    task automatic run_txn(input vec_t v);
        int n;
        int done0;
        done0 = inst_valid_cnt + data_valid_cnt;
        if (v.is_data) begin
            data_req = 1'b1; data_wr = v.wr; data_size = v.size;
            data_addr = v.addr; data_wdata = v.wdata;
            exp_data_q.push_back(v.rdata);
        end else begin
            inst_req = 1'b1; inst_addr = v.addr;
            exp_inst_q.push_back(v.rdata);
        end
        wait_req(n);
        check("issue_cycles", 64'(n), 64'd1);
        serve(v);
        data_req = 1'b0;
        inst_req = 1'b0;
        check("one_valid_per_txn", 64'(inst_valid_cnt + data_valid_cnt - done0), 64'd1);
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int n;
        int s0;
        int v0;
        vec_t v;

        rst = 1'b0; flush = 1'b0;
        inst_req = 1'b0; inst_addr = 32'd0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'd0; data_wdata = 32'd0;
        bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b0; bus_if.bus_rdata = 32'd0;

        vecs[0] = mk(1'b0, 1'b0, SIZE_W, 32'hbfc00000, 32'd0,        32'h24080001, 0, 0);
        vecs[1] = mk(1'b1, 1'b0, SIZE_W, 32'h80000010, 32'd0,        32'h11223344, 0, 0);
        vecs[2] = mk(1'b1, 1'b1, SIZE_B, 32'h80000003, 32'h000000aa, 32'd0,        1, 2);
        vecs[3] = mk(1'b1, 1'b0, SIZE_H, 32'h80000006, 32'd0,        32'h0000beef, 5, 0);
        vecs[4] = mk(1'b0, 1'b0, SIZE_W, 32'hbfc00004, 32'd0,        32'h8c820000, 2, 3);
        vecs[5] = mk(1'b1, 1'b1, SIZE_H, 32'h8000000a, 32'h00001234, 32'd0,        0, 1);

        // Reset state
        tick();
        tick();
        check("rst_bus_req", {63'd0, bus_if.bus_req}, 64'd0);
        check("rst_bus_addr", {32'd0, bus_if.bus_addr}, 64'd0);
        check("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        check("rst_data_valid", {63'd0, data_valid}, 64'd0);
        rst = 1'b1;
        tick();

        // Table of single transactions
        for (int i = 0; i < 6; i++) begin
            s0 = pc_stall_cnt;
            run_txn(vecs[i]);
            if (i == 0) check("fetch0_stall_cycles", 64'(pc_stall_cnt - s0), 64'd2);
        end

        // Simultaneous store and fetch after a fresh reset
        reset_dut();
        data_req = 1'b1; data_wr = 1'b1; data_size = SIZE_W;
        data_addr = 32'h80001000; data_wdata = 32'hdeadbeef;
        inst_req = 1'b1; inst_addr = 32'hbfc00100;
        exp_data_q.push_back(32'd0);
        exp_inst_q.push_back(32'h00000042);
        wait_req(n);
        check("both_issue_cycles", 64'(n), 64'd1);
`ifdef ARB_RR_EN
        check("rr_other_stall", {63'd0, stallreq_from_mem}, 64'd1);
        serve(mk(1'b0, 1'b0, SIZE_W, 32'hbfc00100, 32'd0, 32'h00000042, 0, 0));
        inst_req = 1'b0;
        wait_req(n);
        check("second_issue_cycles", 64'(n), 64'd1);
        serve(mk(1'b1, 1'b1, SIZE_W, 32'h80001000, 32'hdeadbeef, 32'd0, 0, 0));
        data_req = 1'b0;
`else
        check("fixed_other_stall", {63'd0, stallreq_from_pc}, 64'd1);
        serve(mk(1'b1, 1'b1, SIZE_W, 32'h80001000, 32'hdeadbeef, 32'd0, 0, 0));
        data_req = 1'b0;
        wait_req(n);
        check("second_issue_cycles", 64'(n), 64'd1);
        serve(mk(1'b0, 1'b0, SIZE_W, 32'hbfc00100, 32'd0, 32'h00000042, 0, 0));
        inst_req = 1'b0;
`endif

        // Flush while waiting for fetch data: result must be dropped
        inst_req = 1'b1; inst_addr = 32'hbfc00200;
        wait_req(n);
        bus_if.bus_addr_ok = 1'b1;
        tick();
        bus_if.bus_addr_ok = 1'b0;
        flush = 1'b1; inst_req = 1'b0;
        tick();
        flush = 1'b0;
        check("flush_idata_req", {63'd0, bus_if.bus_req}, 64'd0);
        bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'h12345678;
        #1;
        check("flush_idata_valid", {63'd0, inst_valid}, 64'd0);
        tick();
        bus_if.bus_data_ok = 1'b0; bus_if.bus_rdata = 32'd0;
        run_txn(mk(1'b0, 1'b0, SIZE_W, 32'hbfc00380, 32'd0, 32'h3c1a8000, 0, 0));

        // Flush during the address phase: request held, result dropped
        inst_req = 1'b1; inst_addr = 32'hbfc00300;
        wait_req(n);
        flush = 1'b1; inst_req = 1'b0;
        tick();
        flush = 1'b0;
        check("flush_iaddr_req_kept", {63'd0, bus_if.bus_req}, 64'd1);
        check("flush_iaddr_addr_kept", {32'd0, bus_if.bus_addr}, {32'd0, 32'hbfc00300});
        bus_if.bus_addr_ok = 1'b1;
        tick();
        bus_if.bus_addr_ok = 1'b0;
        bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'haaaa5555;
        #1;
        check("flush_iaddr_valid", {63'd0, inst_valid}, 64'd0);
        tick();
        bus_if.bus_data_ok = 1'b0; bus_if.bus_rdata = 32'd0;

        // Flush coincident with data_ok: no valid, back to idle with nothing pending
        inst_req = 1'b1; inst_addr = 32'hbfc00400;
        wait_req(n);
        bus_if.bus_addr_ok = 1'b1;
        tick();
        bus_if.bus_addr_ok = 1'b0;
        flush = 1'b1; inst_req = 1'b0;
        bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'h0badf00d;
        #1;
        check("flush_coincident_valid", {63'd0, inst_valid}, 64'd0);
        tick();
        flush = 1'b0; bus_if.bus_data_ok = 1'b0; bus_if.bus_rdata = 32'd0;
        run_txn(mk(1'b0, 1'b0, SIZE_W, 32'hbfc00404, 32'd0, 32'h11111111, 0, 0));

        // Asynchronous reset in D_DATA, then a stray data_ok
        data_req = 1'b1; data_wr = 1'b0; data_size = SIZE_W; data_addr = 32'h80002000;
        wait_req(n);
        bus_if.bus_addr_ok = 1'b1;
        tick();
        bus_if.bus_addr_ok = 1'b0;
        #2;
        rst = 1'b0; data_req = 1'b0;
        #1;
        check("arst_bus_req", {63'd0, bus_if.bus_req}, 64'd0);
        check("arst_bus_addr", {32'd0, bus_if.bus_addr}, 64'd0);
        check("arst_bus_wr", {63'd0, bus_if.bus_wr}, 64'd0);
        check("arst_bus_size", {62'd0, bus_if.bus_size}, 64'd0);
        check("arst_bus_wdata", {32'd0, bus_if.bus_wdata}, 64'd0);
        check("arst_data_valid", {63'd0, data_valid}, 64'd0);
        check("arst_stall_mem", {63'd0, stallreq_from_mem}, 64'd0);
        check("arst_data_rdata", {32'd0, data_rdata}, 64'd0);
        tick();
        rst = 1'b1;
        v0 = data_valid_cnt;
        bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'hcafef00d;
        #1;
        check("stray_data_valid", {63'd0, data_valid}, 64'd0);
        check("stray_inst_valid", {63'd0, inst_valid}, 64'd0);
        tick();
        bus_if.bus_data_ok = 1'b0; bus_if.bus_rdata = 32'd0;
        check("stray_no_valid_count", 64'(data_valid_cnt - v0), 64'd0);
        check("stray_bus_req", {63'd0, bus_if.bus_req}, 64'd0);

        check("inst_queue_drained", 64'(exp_inst_q.size()), 64'd0);
        check("data_queue_drained", 64'(exp_data_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
